// File: rtl/id_branch_predictor_if.sv
// Fetch-side prediction port and ID-stage training port of id_branch_predictor.
// The master drives fetch/resolve information; the slave (predictor) returns the prediction.
interface id_branch_predictor_if;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        IF_valid;
  logic        IF_stall;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;

  modport master (
    output IF_pc, IF_inst, IF_valid, IF_stall, upd_valid, upd_pc, upd_taken,
    input  pred_taken, pred_target
  );

  modport slave (
    input  IF_pc, IF_inst, IF_valid, IF_stall, upd_valid, upd_pc, upd_taken,
    output pred_taken, pred_target
  );
endinterface

// File: rtl/id_branch_predictor.sv
// IF-stage branch predictor: pre-decode, saturating-counter table trained by ID,
// and an optional return-address stack for jr/jalr $31 built when BRANCH_RAS_EN is defined.
module id_branch_predictor #(
  parameter int ENTRY_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int RAS_DEPTH  = 4
) (
  input logic                  clk,
  input logic                  reset,
  id_branch_predictor_if.slave bp
);
  localparam int N_ENTRY = 1 << ENTRY_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [5:0]  opcode;
  logic        is_cond;
  logic        is_jump;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [ENTRY_BITS-1:0] if_idx;
  logic [ENTRY_BITS-1:0] upd_idx;
  logic [N_ENTRY-1:0][CTR_BITS-1:0] ctr_vec;
  logic        ctr_taken;
  logic        ras_hit;
  logic [31:0] ras_top_data;
  logic        pred_taken_next;
  logic [31:0] pred_target_next;
  logic        unused_bits;

  assign opcode    = bp.IF_inst[31:26];
  // regimm branches are rt in {00000, 00001, 10000, 10001}: only rt[3:1] must be zero
  assign is_cond   = (opcode[5:2] == 4'b0001) ||
                     (opcode == 6'b000001 && bp.IF_inst[19:17] == 3'b000);
  assign is_jump   = (opcode[5:1] == 5'b00001);
  assign pc_plus4  = bp.IF_pc + 32'd4;
  assign br_target = pc_plus4 + {{14{bp.IF_inst[15]}}, bp.IF_inst[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], bp.IF_inst[25:0], 2'b00};
  assign if_idx    = bp.IF_pc[ENTRY_BITS+1:2];
  assign upd_idx   = bp.upd_pc[ENTRY_BITS+1:2];
  assign ctr_taken = ctr_vec[if_idx][CTR_BITS-1];

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRY; gi++) begin : g_ctr
      logic [CTR_BITS-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= CTR_INIT;
        end else if (bp.upd_valid && upd_idx == ENTRY_BITS'(gi)) begin
          if (bp.upd_taken) begin
            if (cnt_reg != CTR_MAX) cnt_reg <= cnt_reg + 1'b1;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      end
      assign ctr_vec[gi] = cnt_reg;
    end
  endgenerate

`ifdef BRANCH_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][31:0] ras_vec;
  logic [PTR_W-1:0] ras_top_reg, ras_top_next, ras_top_inc, ras_top_dec, ras_wr_ptr;
  logic [CNT_W-1:0] ras_cnt_reg, ras_cnt_next;
  logic             ras_wr_en;
  logic             is_jr, is_jalr, rs_ra, ras_act, do_push, do_pop;

  assign is_jr        = (opcode == 6'b000000) && (bp.IF_inst[5:0] == 6'b001000);
  assign is_jalr      = (opcode == 6'b000000) && (bp.IF_inst[5:0] == 6'b001001);
  assign rs_ra        = (bp.IF_inst[25:21] == 5'd31);
  assign ras_hit      = (is_jr || is_jalr) && rs_ra && (ras_cnt_reg != '0);
  assign ras_top_data = ras_vec[ras_top_reg];
  assign ras_act      = bp.IF_valid && !bp.IF_stall;
  assign do_push      = ras_act && ((opcode == 6'b000011) || is_jalr);
  assign do_pop       = ras_act && ras_hit;
  assign ras_top_inc  = (ras_top_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_top_reg + 1'b1;
  assign ras_top_dec  = (ras_top_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_top_reg - 1'b1;

  // jalr $31 pops and pushes at once: the top slot is simply overwritten in place
  always_comb begin
    ras_top_next = ras_top_reg;
    ras_cnt_next = ras_cnt_reg;
    ras_wr_en    = 1'b0;
    ras_wr_ptr   = ras_top_reg;
    if (do_push && do_pop) begin
      ras_wr_en = 1'b1;
    end else if (do_push) begin
      ras_wr_en    = 1'b1;
      ras_wr_ptr   = ras_top_inc;
      ras_top_next = ras_top_inc;
      if (ras_cnt_reg != CNT_W'(RAS_DEPTH)) ras_cnt_next = ras_cnt_reg + 1'b1;
    end else if (do_pop) begin
      ras_top_next = ras_top_dec;
      ras_cnt_next = ras_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_top_reg <= '0;
      ras_cnt_reg <= '0;
    end else begin
      ras_top_reg <= ras_top_next;
      ras_cnt_reg <= ras_cnt_next;
    end
  end

  for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
    logic [31:0] slot_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) slot_reg <= '0;
      else if (ras_wr_en && ras_wr_ptr == PTR_W'(gi)) slot_reg <= bp.IF_pc + 32'd8;
    end
    assign ras_vec[gi] = slot_reg;
  end

  assign unused_bits = ^{bp.upd_pc[31:ENTRY_BITS+2], bp.upd_pc[1:0]};
`else
  assign ras_hit      = 1'b0;
  assign ras_top_data = '0;
  assign unused_bits  = ^{bp.upd_pc[31:ENTRY_BITS+2], bp.upd_pc[1:0], bp.IF_stall};
`endif

  always_comb begin
    pred_taken_next  = 1'b0;
    pred_target_next = pc_plus4;
    if (bp.IF_valid) begin
      if (is_cond) begin
        pred_taken_next = ctr_taken;
        if (ctr_taken) pred_target_next = br_target;
      end else if (is_jump) begin
        pred_taken_next  = 1'b1;
        pred_target_next = j_target;
      end else if (ras_hit) begin
        pred_taken_next  = 1'b1;
        pred_target_next = ras_top_data;
      end
    end
  end

  assign bp.pred_taken  = pred_taken_next;
  assign bp.pred_target = pred_target_next;
endmodule

// File: tb/tb_id_branch_predictor.sv
// Randomized self-checking bench for id_branch_predictor against a queue/array reference model;
// RAS expectations follow BRANCH_RAS_EN as seen by this compilation.
module tb_id_branch_predictor;
  localparam int ENTRY_BITS = 6;
  localparam int CTR_BITS   = 2;
  localparam int RAS_DEPTH  = 4;
  localparam int N_ENTRY    = 1 << ENTRY_BITS;
  localparam int CTR_MAXV   = (1 << CTR_BITS) - 1;
  localparam int CTR_INITV  = (1 << (CTR_BITS - 1)) - 1;
  localparam logic [31:0] JR31   = {6'd0, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] JALR31 = {6'd0, 5'd31, 5'd0, 5'd31, 5'd0, 6'h09};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_branch_predictor_if bp_if ();
  id_branch_predictor #(.ENTRY_BITS(ENTRY_BITS), .CTR_BITS(CTR_BITS), .RAS_DEPTH(RAS_DEPTH))
    dut (.clk(clk), .reset(reset), .bp(bp_if));

  int          n_vec = 0;
  int          n_err = 0;
  int          mctr[N_ENTRY];
  logic [31:0] mras[$];
  logic        exp_t;
  logic [31:0] exp_tgt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_beq(logic [15:0] imm);
    return {6'd4, 5'd1, 5'd2, imm};
  endfunction
  function automatic logic [31:0] f_jump(logic [5:0] op, logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic model_reset();
    foreach (mctr[i]) mctr[i] = CTR_INITV;
    mras.delete();
  endtask

  // Reference prediction computed from the instruction classes and current model state
  task automatic model_pred(logic [31:0] pc, logic [31:0] inst, logic valid);
    int op, rt, rs, fn, idx;
    op = int'(inst[31:26]); rt = int'(inst[20:16]); rs = int'(inst[25:21]); fn = int'(inst[5:0]);
    idx = int'((pc >> 2) % N_ENTRY);
    exp_t = 1'b0;
    exp_tgt = pc + 32'd4;
    if (valid) begin
      if ((op >= 4 && op <= 7) || (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17))) begin
        exp_t = (mctr[idx] >= (1 << (CTR_BITS - 1)));
        if (exp_t) exp_tgt = pc + 32'd4 + 32'(int'($signed(inst[15:0])) * 4);
      end else if (op == 2 || op == 3) begin
        exp_t = 1'b1;
        exp_tgt = ((pc + 32'd4) & 32'hF000_0000) | (32'(inst[25:0]) * 4);
      end
`ifdef BRANCH_RAS_EN
      else if (op == 0 && (fn == 8 || fn == 9) && rs == 31 && mras.size() > 0) begin
        exp_t = 1'b1;
        exp_tgt = mras[$];
      end
`endif
    end
  endtask

  task automatic model_update();
    int idx, op, fn, rs;
    if (bp_if.upd_valid) begin
      idx = int'((bp_if.upd_pc >> 2) % N_ENTRY);
      if (bp_if.upd_taken) mctr[idx] = (mctr[idx] < CTR_MAXV) ? mctr[idx] + 1 : CTR_MAXV;
      else                 mctr[idx] = (mctr[idx] > 0) ? mctr[idx] - 1 : 0;
    end
`ifdef BRANCH_RAS_EN
    op = int'(bp_if.IF_inst[31:26]); fn = int'(bp_if.IF_inst[5:0]); rs = int'(bp_if.IF_inst[25:21]);
    if (bp_if.IF_valid && !bp_if.IF_stall) begin
      if (op == 0 && (fn == 8 || fn == 9) && rs == 31 && mras.size() > 0) void'(mras.pop_back());
      if (op == 3 || (op == 0 && fn == 9)) mras.push_back(bp_if.IF_pc + 32'd8);
      if (mras.size() > RAS_DEPTH) void'(mras.pop_front());
    end
`else
    op = 0; fn = 0; rs = 0;
`endif
  endtask

  task automatic apply(string tag, logic [31:0] pc, logic [31:0] inst, logic valid, logic stall,
                       logic uv, logic [31:0] upc, logic ut);
    bp_if.IF_pc = pc; bp_if.IF_inst = inst; bp_if.IF_valid = valid; bp_if.IF_stall = stall;
    bp_if.upd_valid = uv; bp_if.upd_pc = upc; bp_if.upd_taken = ut;
    #1;
    model_pred(pc, inst, valid);
    check({tag, "_taken"}, 32'(bp_if.pred_taken), 32'(exp_t));
    check({tag, "_target"}, bp_if.pred_target, exp_tgt);
    $display("%s: pc=%h inst=%h v=%0d st=%0d upd=%0d/%h/%0d -> taken=%0d target=%h",
             tag, pc, inst, valid, stall, uv, upc, ut, bp_if.pred_taken, bp_if.pred_target);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic train(logic [31:0] upc, logic ut);
    apply("train", 32'h0000_7000, 32'h0, 1'b0, 1'b0, 1'b1, upc, ut);
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h3000 + 32'($urandom_range(0, 15) * 4) + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    return {6'(3'($urandom_range(4, 7))), r[25:0]};
      2:       return {6'd1, r[25:21], 5'({r[4], 3'b000, r[5]}), r[15:0]};
      3:       return {6'd1, r[25:21], 5'd2, r[15:0]};
      4:       return {6'd2, r[25:0]};
      5:       return {6'd3, r[25:0]};
      6:       return JR31;
      7:       return JALR31;
      8:       return {6'd0, r[25:21], 15'd0, r[0] ? 6'h09 : 6'h08};
      default: return r[0] ? {6'h23, r[25:0]} : {6'd0, r[25:11], 5'd0, 6'h20};
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bp_if.IF_pc = '0; bp_if.IF_inst = '0; bp_if.IF_valid = 1'b0; bp_if.IF_stall = 1'b0;
    bp_if.upd_valid = 1'b0; bp_if.upd_pc = '0; bp_if.upd_taken = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset defaults
    apply("rst_beq", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_beq_t_const", 32'(bp_if.pred_taken), 32'd0);
    check("rst_beq_tgt_const", bp_if.pred_target, 32'h3004);
    tick();
    apply("rst_j", 32'h3000, f_jump(6'd2, 26'h0000C00), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_j_t_const", 32'(bp_if.pred_taken), 32'd1);
    check("rst_j_tgt_const", bp_if.pred_target, 32'h3000);
    tick();

    // Training and saturation
    train(32'h3000, 1'b1);
    train(32'h3000, 1'b1);
    apply("trained", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("trained_t_const", 32'(bp_if.pred_taken), 32'd1);
    check("trained_tgt_const", bp_if.pred_target, 32'h3014);
    tick();
    for (int i = 0; i < 3; i++) train(32'h3000, 1'b1);
    train(32'h3000, 1'b0);
    apply("sat_one_nt", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("sat_one_nt_const", 32'(bp_if.pred_taken), 32'd1);
    tick();
    train(32'h3000, 1'b0);
    apply("sat_two_nt", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("sat_two_nt_const", 32'(bp_if.pred_taken), 32'd0);
    tick();

    // Asynchronous reset takes effect before any clock edge
    train(32'h3000, 1'b1);
    apply("pre_async", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_rst_const", 32'(bp_if.pred_taken), 32'd0);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // Same-cycle read/update of one entry
    apply("same_cyc", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b1, 32'h3000, 1'b1);
    check("same_cyc_old_const", 32'(bp_if.pred_taken), 32'd0);
    tick();
    apply("same_cyc_next", 32'h3000, f_beq(16'h0004), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("same_cyc_new_const", 32'(bp_if.pred_taken), 32'd1);
    tick();

`ifdef BRANCH_RAS_EN
    do_reset();
    apply("ras_jal", 32'h3000, f_jump(6'd3, 26'h100), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    apply("ras_jr", 32'h0400, JR31, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ras_jr_t_const", 32'(bp_if.pred_taken), 32'd1);
    check("ras_jr_tgt_const", bp_if.pred_target, 32'h3008);
    tick();
    apply("ras_empty", 32'h3008, JR31, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ras_empty_const", 32'(bp_if.pred_taken), 32'd0);
    tick();

    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply("ovf_jal", 32'h3000 + 32'(k * 32'h100), f_jump(6'd3, 26'h100), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      apply("ovf_pop", 32'h5000, JR31, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("ovf_pop_tgt_const", bp_if.pred_target, 32'h3408 - 32'(k * 32'h100));
      tick();
    end
    apply("ovf_fifth", 32'h5000, JR31, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ovf_fifth_const", 32'(bp_if.pred_taken), 32'd0);
    tick();
    apply("stall_jal", 32'h3500, f_jump(6'd3, 26'h100), 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    apply("stall_jr", 32'h5000, JR31, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("stall_nopush_const", 32'(bp_if.pred_taken), 32'd0);
    tick();
`else
    do_reset();
    apply("noras_jal", 32'h3000, f_jump(6'd3, 26'h100), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    apply("noras_jr", 32'h0400, JR31, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("noras_jr_t_const", 32'(bp_if.pred_taken), 32'd0);
    check("noras_jr_tgt_const", bp_if.pred_target, 32'h0404);
    tick();
`endif

    // Randomized traffic with one reset landing mid-operation
    do_reset();
    for (int n = 0; n < 600; n++) begin
      apply("rand", rand_pc(), rand_inst(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 1), rand_pc(), ($urandom_range(0, 2) != 0));
      if (n == 300) begin
        reset = 1'b1;
        #1;
        model_reset();
        model_pred(bp_if.IF_pc, bp_if.IF_inst, bp_if.IF_valid);
        check("mid_rst_taken", 32'(bp_if.pred_taken), 32'(exp_t));
        check("mid_rst_target", bp_if.pred_target, exp_tgt);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
